// File: rtl/logic_channel_fifo_if.sv
// Bus bundle for logic_channel_fifo: channelised input stream and tagged merged output stream.
// The slave modport is the FIFO's view; master is the producer/consumer side.
interface logic_channel_fifo_if #(
  parameter int WIDTH         = 1,
  parameter int CHANNEL_WIDTH = 2
);
  logic                     rx_tvalid;
  logic [CHANNEL_WIDTH-1:0] rx_tdest;
  logic [WIDTH-1:0]         rx_tdata;
  logic                     rx_tready;
  logic                     tx_tready;
  logic                     tx_tvalid;
  logic [CHANNEL_WIDTH-1:0] tx_tid;
  logic [WIDTH-1:0]         tx_tdata;

  modport master (
    output rx_tvalid, rx_tdest, rx_tdata, tx_tready,
    input  rx_tready, tx_tvalid, tx_tid, tx_tdata
  );

  modport slave (
    input  rx_tvalid, rx_tdest, rx_tdata, tx_tready,
    output rx_tready, tx_tvalid, tx_tid, tx_tdata
  );
endinterface

// File: rtl/logic_channel_fifo.sv
// Multi-channel FIFO: CHANNELS queues in one statically partitioned memory, merged onto one stream.
// Define LOGIC_CHANNEL_FIFO_STRICT_PRIORITY_EN for fixed-priority instead of round-robin arbitration.
module logic_channel_fifo #(
  parameter int    WIDTH         = 1,
  parameter int    CHANNELS      = 4,
  parameter int    CAPACITY      = 16,
  parameter int    ADDRESS_WIDTH = $clog2(CAPACITY),
  parameter int    CHANNEL_WIDTH = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  parameter string TARGET        = "GENERIC"
) (
  input logic                 aclk,
  input logic                 sreset,
  logic_channel_fifo_if.slave bus
);
  localparam int PW = ADDRESS_WIDTH + 1;
  localparam int MW = CHANNEL_WIDTH + ADDRESS_WIDTH;

  logic [PW-1:0]            wr_ptr_q [CHANNELS];
  logic [PW-1:0]            wr_ptr_d [CHANNELS];
  logic [PW-1:0]            rd_ptr_q [CHANNELS];
  logic [PW-1:0]            rd_ptr_d [CHANNELS];
  logic [CHANNELS-1:0]      empty;
  logic [CHANNELS-1:0]      full;
  logic                     dest_ok;
  logic                     rx_ready;
  logic                     wr_en;
  logic                     load;
  logic                     rd_en;
  logic                     grant_vld;
  logic [CHANNEL_WIDTH-1:0] grant;
  logic [MW-1:0]            waddr;
  logic [MW-1:0]            raddr;
  logic [WIDTH-1:0]         rdata;
  logic                     tx_vld_q, tx_vld_d;
  logic [CHANNEL_WIDTH-1:0] tx_id_q, tx_id_d;
  logic [WIDTH-1:0]         tx_data_q, tx_data_d;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]  = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                 (wr_ptr_q[c][PW-2:0] == rd_ptr_q[c][PW-2:0]);
    end
  end

  // Out-of-range destinations are always accepted and silently dropped.
  assign dest_ok       = int'(bus.rx_tdest) < CHANNELS;
  assign rx_ready      = !sreset && (!dest_ok || !full[bus.rx_tdest]);
  assign bus.rx_tready = rx_ready;
  assign wr_en         = bus.rx_tvalid && rx_ready && dest_ok;
  assign load          = !tx_vld_q || bus.tx_tready;
  assign rd_en         = load && grant_vld;

`ifdef LOGIC_CHANNEL_FIFO_STRICT_PRIORITY_EN
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        grant     = CHANNEL_WIDTH'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [CHANNEL_WIDTH-1:0] last_q, last_d;
  int                       idx;

  // Descending scan so the nearest channel after the last grant is the final (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = (int'(last_q) + 1 + i) % CHANNELS;
      if (!empty[idx]) begin
        grant     = CHANNEL_WIDTH'(idx);
        grant_vld = 1'b1;
      end
    end
    last_d = rd_en ? grant : last_q;
  end

  always_ff @(posedge aclk) begin
    if (sreset) last_q <= CHANNEL_WIDTH'(CHANNELS - 1);
    else        last_q <= last_d;
  end
`endif

  assign waddr = {bus.rx_tdest, wr_ptr_q[bus.rx_tdest][ADDRESS_WIDTH-1:0]};
  assign raddr = {grant, rd_ptr_q[grant][ADDRESS_WIDTH-1:0]};

  generate
    if (TARGET == "GENERIC") begin : g_generic
      logic [WIDTH-1:0] mem [2**MW];
      always_ff @(posedge aclk) if (wr_en) mem[waddr] <= bus.rx_tdata;
      assign rdata = mem[raddr];
    end else begin : g_lutram
      (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [2**MW];
      always_ff @(posedge aclk) if (wr_en) mem[waddr] <= bus.rx_tdata;
      assign rdata = mem[raddr];
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + PW'(wr_en && (bus.rx_tdest == CHANNEL_WIDTH'(c)));
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(rd_en && (grant == CHANNEL_WIDTH'(c)));
    end
    tx_vld_d  = load  ? grant_vld : tx_vld_q;
    tx_id_d   = rd_en ? grant     : tx_id_q;
    tx_data_d = rd_en ? rdata     : tx_data_q;
  end

  // Output register stage: the only read pipeline stage.
  always_ff @(posedge aclk) begin
    if (sreset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      tx_vld_q  <= 1'b0;
      tx_id_q   <= '0;
      tx_data_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      tx_vld_q  <= tx_vld_d;
      tx_id_q   <= tx_id_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.tx_tvalid = tx_vld_q;
  assign bus.tx_tid    = tx_id_q;
  assign bus.tx_tdata  = tx_data_q;
endmodule

// File: tb/tb_logic_channel_fifo.sv
// Self-checking bench for logic_channel_fifo: queue-level reference model plus directed scenarios.
module tb_logic_channel_fifo;
  localparam int W = 8, CH = 4, CAP = 16, CW = 2;

  logic aclk = 1'b0;
  logic sreset = 1'b1;
  always #5 aclk = ~aclk;

  logic_channel_fifo_if #(.WIDTH(W), .CHANNEL_WIDTH(CW)) bus ();
  logic_channel_fifo #(.WIDTH(W), .CHANNELS(CH), .CAPACITY(CAP)) dut (
    .aclk(aclk), .sreset(sreset), .bus(bus));

  logic_channel_fifo_if #(.WIDTH(W), .CHANNEL_WIDTH(2)) bus3 ();
  logic_channel_fifo #(.WIDTH(W), .CHANNELS(3), .CAPACITY(4)) dut3 (
    .aclk(aclk), .sreset(sreset), .bus(bus3));

  int npass = 0, ntotal = 0;
  int cyc = 0;
  int log_id[$], log_d[$], log_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference model: per-channel circular queues plus the one-beat output register.
  logic [W-1:0] mbuf [CH][CAP];
  int  mhead [CH];
  int  mcnt  [CH];
  bit  m_v = 1'b0;
  int  m_id = 0;
  int  m_d = 0;
  int  m_last = CH - 1;
  bit  m_acc, m_load;
  int  m_g, m_dst;

  function automatic bit exp_ready();
    return !sreset && (int'(bus.rx_tdest) >= CH || mcnt[bus.rx_tdest] < CAP);
  endfunction

  always @(posedge aclk) begin
    if (sreset) begin
      for (int c = 0; c < CH; c++) begin mhead[c] = 0; mcnt[c] = 0; end
      m_v = 1'b0; m_id = 0; m_d = 0; m_last = CH - 1;
    end else begin
      m_acc  = bus.rx_tvalid && exp_ready();
      m_dst  = int'(bus.rx_tdest);
      m_load = !m_v || bus.tx_tready;
      if (m_load) begin
        m_g = -1;
`ifdef LOGIC_CHANNEL_FIFO_STRICT_PRIORITY_EN
        for (int k = 0; k < CH; k++) if (m_g < 0 && mcnt[k] > 0) m_g = k;
`else
        for (int k = 1; k <= CH; k++) if (m_g < 0 && mcnt[(m_last + k) % CH] > 0) m_g = (m_last + k) % CH;
`endif
        if (m_g >= 0) begin
          m_v = 1'b1; m_id = m_g; m_d = int'(mbuf[m_g][mhead[m_g]]);
          mhead[m_g] = (mhead[m_g] + 1) % CAP; mcnt[m_g]--; m_last = m_g;
        end else m_v = 1'b0;
      end
      if (m_acc && m_dst < CH) begin
        mbuf[m_dst][(mhead[m_dst] + mcnt[m_dst]) % CAP] = bus.rx_tdata;
        mcnt[m_dst]++;
      end
    end
  end

  always @(negedge aclk) begin
    cyc++;
    chk("tx_tvalid", int'(bus.tx_tvalid), int'(m_v));
    chk("rx_tready", int'(bus.rx_tready), int'(exp_ready()));
    if (m_v) begin
      chk("tx_tid", int'(bus.tx_tid), m_id);
      chk("tx_tdata", int'(bus.tx_tdata), m_d);
    end
    if (!sreset && bus.tx_tvalid && bus.tx_tready) begin
      log_id.push_back(int'(bus.tx_tid));
      log_d.push_back(int'(bus.tx_tdata));
      log_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic clear_log();
    log_id.delete(); log_d.delete(); log_cyc.delete();
  endtask

  int acc;
  int e_id, e_d;

  initial begin
    bus.rx_tvalid = 1'b1; bus.rx_tdest = 2'd2; bus.rx_tdata = 8'h11; bus.tx_tready = 1'b0;
    bus3.rx_tvalid = 1'b0; bus3.rx_tdest = '0; bus3.rx_tdata = '0; bus3.tx_tready = 1'b1;
    repeat (3) step();
    chk("rst rx_tready", int'(bus.rx_tready), 0);
    chk("rst tx_tvalid", int'(bus.tx_tvalid), 0);
    chk("rst tx_tid", int'(bus.tx_tid), 0);
    chk("rst tx_tdata", int'(bus.tx_tdata), 0);

    // Single beat latency: write at edge 0, visible after edge 1.
    bus.rx_tdata = 8'hA5; sreset = 1'b0;
    step();
    bus.rx_tvalid = 1'b0;
    chk("lat e0 tx_tvalid", int'(bus.tx_tvalid), 0);
    step();
    chk("lat e1 tx_tvalid", int'(bus.tx_tvalid), 1);
    chk("lat e1 tx_tid", int'(bus.tx_tid), 2);
    chk("lat e1 tx_tdata", int'(bus.tx_tdata), 8'hA5);
    bus.tx_tready = 1'b1; step(); bus.tx_tready = 1'b0; step();

    // Fill channel 1 with the consumer stalled.
    clear_log(); acc = 0;
    bus.rx_tvalid = 1'b1; bus.rx_tdest = 2'd1;
    for (int i = 0; i < 20; i++) begin
      bus.rx_tdata = W'(i);
      @(negedge aclk); if (bus.rx_tready) acc++;
      step();
    end
    bus.rx_tvalid = 1'b0;
    chk("fill accepted", acc, 17);
    #1 chk("full ch1 rx_tready", int'(bus.rx_tready), 0);
    bus.rx_tdest = 2'd0;
    #1 chk("ch0 rx_tready", int'(bus.rx_tready), 1);
    bus.tx_tready = 1'b1; repeat (20) step(); bus.tx_tready = 1'b0;
    chk("fill drained", log_id.size(), 17);
    for (int i = 0; i < 17 && i < log_id.size(); i++) begin
      chk("fill tid", log_id[i], 1);
      chk("fill data", log_d[i], i);
    end

    // Three beats per channel, then drain.
    clear_log();
    bus.rx_tvalid = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 3; k++) begin
        bus.rx_tdest = CW'(c); bus.rx_tdata = W'(c * 16 + k); step();
      end
    bus.rx_tvalid = 1'b0;
    bus.tx_tready = 1'b1; repeat (16) step(); bus.tx_tready = 1'b0;
    chk("arb count", log_id.size(), 12);
    for (int i = 0; i < 12 && i < log_id.size(); i++) begin
`ifdef LOGIC_CHANNEL_FIFO_STRICT_PRIORITY_EN
      e_id = i / 3; e_d = (i / 3) * 16 + i % 3;
`else
      e_id = i % 4; e_d = (i % 4) * 16 + i / 4;
`endif
      chk("arb tid", log_id[i], e_id);
      chk("arb data", log_d[i], e_d);
    end
    if (log_id.size() >= 5) begin
`ifdef LOGIC_CHANNEL_FIFO_STRICT_PRIORITY_EN
      chk("arb tid[1] literal", log_id[1], 0);
      chk("arb tid[4] literal", log_id[4], 1);
`else
      chk("arb tid[1] literal", log_id[1], 1);
      chk("arb tid[4] literal", log_id[4], 0);
`endif
    end

    // Stream 40 beats through channel 3 at full rate.
    clear_log();
    bus.tx_tready = 1'b1; bus.rx_tvalid = 1'b1; bus.rx_tdest = 2'd3;
    for (int i = 0; i < 40; i++) begin bus.rx_tdata = W'(i); step(); end
    bus.rx_tvalid = 1'b0;
    repeat (4) step();
    bus.tx_tready = 1'b0;
    chk("stream count", log_id.size(), 40);
    for (int i = 0; i < 40 && i < log_id.size(); i++) begin
      chk("stream tid", log_id[i], 3);
      chk("stream data", log_d[i], i);
      chk("stream gapless", log_cyc[i], log_cyc[0] + i);
    end

    // Out-of-range destination on the three-channel instance.
    bus3.rx_tvalid = 1'b1; bus3.rx_tdest = 2'd3; bus3.rx_tdata = 8'd77;
    #1 chk("oor rx_tready", int'(bus3.rx_tready), 1);
    step();
    bus3.rx_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("oor tx_tvalid", int'(bus3.tx_tvalid), 0);
    end
    bus3.rx_tvalid = 1'b1; bus3.rx_tdest = 2'd2; bus3.rx_tdata = 8'd9;
    step(); bus3.rx_tvalid = 1'b0; step();
    chk("ch3inst tx_tvalid", int'(bus3.tx_tvalid), 1);
    chk("ch3inst tx_tid", int'(bus3.tx_tid), 2);
    chk("ch3inst tx_tdata", int'(bus3.tx_tdata), 9);

    // Reset while beats are queued and the output register is full.
    clear_log();
    bus.rx_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_tdest = CW'(i % 4); bus.rx_tdata = W'(8'hC0 + i); step();
    end
    bus.rx_tvalid = 1'b0; step();
    chk("pre-reset tx_tvalid", int'(bus.tx_tvalid), 1);
    sreset = 1'b1; step();
    chk("mid-reset tx_tvalid", int'(bus.tx_tvalid), 0);
    chk("mid-reset rx_tready", int'(bus.rx_tready), 0);
    sreset = 1'b0; bus.tx_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk("post-reset tx_tvalid", int'(bus.tx_tvalid), 0);
    end
    chk("post-reset drained", log_id.size(), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
